// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register slice: slot state encoding and sizing helpers.
package pipe_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_BUSY  = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_e;

    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid/ready pipeline slot. SKID=1 adds a second register so in_ready_o comes straight from a flop;
// SKID=0 is a single register whose ready follows the downstream ready combinationally.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int PAY_W  = 41,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PAY_W-1:0] in_pay_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PAY_W-1:0] out_pay_o
);

    // Control bits live in the low CTRL_W bits of the payload.
    localparam logic [PAY_W-1:0] CTRL_MASK = {{(PAY_W-CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

    slot_state_e      state_q, state_d;
    logic [PAY_W-1:0] main_q, skid_q;
    logic             accept, drain;
    logic             load_main, load_skid, skid_to_main;

    assign out_valid_o = (state_q != SLOT_EMPTY);
    assign out_pay_o   = main_q;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready_o = (state_q != SLOT_FULL);
        end else begin : g_noskid
            assign in_ready_o = (state_q == SLOT_EMPTY) || out_ready_i;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        accept       = in_valid_i && in_ready_o && !flush_i;
        drain        = out_valid_o && out_ready_i;
        case (state_q)
            SLOT_EMPTY: begin
                if (accept) begin
                    state_d   = SLOT_BUSY;
                    load_main = 1'b1;
                end
            end
            SLOT_BUSY: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    // Only reachable with a skid register: downstream stalled while we accepted.
                    state_d   = SLOT_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (drain) begin
                    state_d      = SLOT_BUSY;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (flush_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            main_q <= main_q & ~CTRL_MASK;
            skid_q <= skid_q & ~CTRL_MASK;
        end else begin
            if (load_main) begin
                main_q <= in_pay_i;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pay_i;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: a chain of STAGES handshake slots with flush, occupancy count and
// control-bit masking so a bubble never carries live control downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int STAGES = 1,
    parameter int SKID   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_data_i,
    input  logic [CTRL_W-1:0]            in_ctrl_i,
    input  logic [ADDR_W-1:0]            in_rd_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_data_o,
    output logic [CTRL_W-1:0]            out_ctrl_o,
    output logic [ADDR_W-1:0]            out_rd_o,
    output logic [occ_width(STAGES)-1:0] occupancy_o
);

    localparam int N     = (STAGES < 1) ? 1 : ((STAGES > MAX_STAGES) ? MAX_STAGES : STAGES);
    localparam int PAY_W = DATA_W + ADDR_W + CTRL_W;
    localparam int OCC_W = occ_width(STAGES);

    logic [N:0]       chain_valid;
    logic [N:0]       chain_ready;
    logic [PAY_W-1:0] chain_pay [N+1];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             top_accept, top_drain;

    assign chain_valid[0] = in_valid_i;
    assign chain_pay[0]   = {in_data_i, in_rd_i, in_ctrl_i};
    assign chain_ready[N] = out_ready_i;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            pipe_skid_slot #(
                .PAY_W  (PAY_W),
                .CTRL_W (CTRL_W),
                .SKID   (SKID)
            ) u_slot (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .flush_i     (flush_i),
                .in_valid_i  (chain_valid[gi]),
                .in_ready_o  (chain_ready[gi]),
                .in_pay_i    (chain_pay[gi]),
                .out_valid_o (chain_valid[gi+1]),
                .out_ready_i (chain_ready[gi+1]),
                .out_pay_o   (chain_pay[gi+1])
            );
        end
    endgenerate

    // Reset masks both handshakes so nothing is seen to transfer while it is asserted.
    assign in_ready_o  = chain_ready[0] && !rst_i;
    assign out_valid_o = chain_valid[N] && !rst_i;
    assign out_data_o  = chain_pay[N][PAY_W-1 -: DATA_W];
    assign out_rd_o    = chain_pay[N][CTRL_W +: ADDR_W];
    assign out_ctrl_o  = out_valid_o ? chain_pay[N][CTRL_W-1:0] : '0;

    assign top_accept = in_valid_i && in_ready_o && !flush_i;
    assign top_drain  = out_valid_o && out_ready_i;

    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (top_accept && !top_drain) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!top_accept && top_drain) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

endmodule
